fanout_capture_checker: RTL and testbench
=========================================

# fanout_capture_checker

Clocked capture-and-compare stage that sits directly downstream of the buffered/cloned fanout network. Registers the network's source signal and all WIDTH replicated outputs every cycle, checks that each replica equals the source, and reports a sticky error flag, a saturating mismatch counter and the index of the first failing replica. It is the on-chip equivalence monitor for optimized fanout trees, where every replica must track its driver.

## Interface
- WIDTH, 20: number of replicated outputs monitored.
- IDX_W, 5: width of the failing-index output; must satisfy 2^IDX_W ≥ WIDTH.
- CNT_W, 16: mismatch counter width.
- SETTLE, 2: cycles to mask comparison after start and after every source transition (1..15).

- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- src  input  1  fanout network source signal.
- rep  input  WIDTH  replicated outputs; rep[i] is out(i+1) of the network.
- start  input  1  begin a check window (level sampled each cycle).
- stop  input  1  end the check window.
- busy  output  1  high in SETTLE or CHECK.
- done  output  1  one-cycle pulse when a window closes.
- err  output  1  sticky: any mismatch seen in the current or last window.
- err_cnt  output  CNT_W  mismatch count, saturating at all-ones.
- first_idx  output  IDX_W  lowest failing index on the first mismatching cycle; 0 if none.

## Operation
- Capture stage: src_q and rep_q are registered every cycle regardless of state; src_qq holds the previous src_q for edge detection.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: start=1 → clear err, err_cnt, first_idx, load settle counter with SETTLE-1, go to SETTLE. stop is ignored; start wins when both are high.
- SETTLE: counter decrements each cycle; at 0 → CHECK. stop=1 → DONE (stop takes priority over expiry).
- CHECK: mismatch vector m = rep_q XOR {WIDTH{src_q}}.
  - If src_q ≠ src_qq (source edge), the cycle is masked, the counter is reloaded with SETTLE-1, and the FSM returns to SETTLE.
  - Otherwise, if m ≠ 0: err←1; err_cnt += 1 (saturating); if err was 0, first_idx ← index of the lowest set bit of m.
  - stop=1 → DONE. The comparison for that same cycle is still performed. start is ignored.
- DONE: done=1 for one cycle → IDLE. err, err_cnt and first_idx hold until the next start.
- rst (any state): FSM→IDLE, all capture registers, err, err_cnt and first_idx → 0.

## Timing
- Reset values: busy=0, done=0, err=0, err_cnt=0, first_idx=0.
- Latency: a mismatch present on pins before edge k is captured at edge k. err, err_cnt and first_idx update at edge k+1.
- start sampled at edge n → busy high after edge n. The first compared sample is the one captured at edge n+SETTLE (SETTLE masked cycles).
- stop sampled at edge n in CHECK → done high after edge n, busy low after edge n. done falls after edge n+1.
- Source-edge mask: after a src transition, SETTLE cycles are masked before comparison resumes, so glitches in slow clones are not counted.
- Saturation: at err_cnt = 2^CNT_W−1, further mismatches leave the counter unchanged. err stays 1.
- rst asserted mid-window aborts the window with no done pulse.

## Configuration
- FANOUT_CHK_POPCOUNT_EN defined: err_cnt increments by popcount(m) per mismatching cycle, saturating. This counts failing replicas rather than failing cycles.
- Undefined: err_cnt increments by exactly 1 per mismatching cycle.
- All other behaviour is identical in both builds.

## Test plan
- Clean run: WIDTH=20, SETTLE=2, src held 1, rep=all ones, start for 1 cycle, stop after 10 cycles → done pulse, err=0, err_cnt=0, first_idx=0.
- Single fault: rep[7] forced 0 for 3 CHECK cycles with src=1 → err=1, err_cnt=3 (POPCOUNT build: 3), first_idx=7, each update appearing 2 edges after the fault.
- Multi-bit fault: rep[3] and rep[12] wrong for 1 cycle → err_cnt=1 without the macro and 2 with it; first_idx=3.
- Source toggle: src 0→1 with rep lagging 1 cycle → masked, err=0; the FSM visits SETTLE for 2 cycles, then CHECK resumes.
- Saturation: CNT_W=4, persistent fault for 20 CHECK cycles → err_cnt=15, holds at 15.
- Priorities and reset:
  - start and stop together in IDLE → enters SETTLE.
  - rst in CHECK with err=1 → all outputs 0 on the next edge, no done pulse.

Source files
------------

// File: rtl/fanout_capture_checker_if.sv
// Purpose: signal bundle between a fanout network under test and its capture checker.
// Latency: none, this is wiring only.
// Backpressure: none, the checker samples every cycle and never stalls.
interface fanout_capture_checker_if #(
    parameter int WIDTH = 20,
    parameter int IDX_W = 5,
    parameter int CNT_W = 16
) ();
    logic             src;
    logic [WIDTH-1:0] rep;
    logic             start;
    logic             stop;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [IDX_W-1:0] first_idx;

    // Stimulus/driver side
    modport master (
        output src, rep, start, stop,
        input  busy, done, err, err_cnt, first_idx
    );

    // Checker side
    modport slave (
        input  src, rep, start, stop,
        output busy, done, err, err_cnt, first_idx
    );
endinterface

// File: rtl/fanout_capture_checker.sv
// Purpose: registers a fanout source and its WIDTH replicas and flags any replica that disagrees.
// Latency: pins -> capture regs 1 edge; capture regs -> err/err_cnt/first_idx 1 more edge.
// Backpressure: none, samples every cycle. Optional FANOUT_CHK_POPCOUNT_EN counts failing replicas.
module fanout_capture_checker #(
    parameter int WIDTH  = 20,
    parameter int IDX_W  = 5,
    parameter int CNT_W  = 16,
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst,
    fanout_capture_checker_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CHECK, ST_DONE} state_t;

    // Sum is wide enough for the counter plus a full-width popcount before saturating.
    localparam int               SUM_W       = CNT_W + IDX_W + 1;
    localparam logic [SUM_W-1:0] CNT_MAX     = SUM_W'({CNT_W{1'b1}});
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic             src_q, src_qq;
    logic [WIDTH-1:0] rep_q;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [WIDTH-1:0] mism;
    logic             src_edge;
    logic [IDX_W-1:0] low_idx;
    logic [SUM_W-1:0] inc;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt_sat;

    assign mism     = rep_q ^ {WIDTH{src_q}};
    assign src_edge = src_q ^ src_qq;

    // Capture stage runs every cycle, independent of the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q  <= 1'b0;
            src_qq <= 1'b0;
            rep_q  <= '0;
        end else begin
            src_q  <= bus.src;
            src_qq <= src_q;
            rep_q  <= bus.rep;
        end
    end

    // Lowest failing replica: scan downward so the smallest set index wins.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mism[i]) low_idx = IDX_W'(i);
        end
    end

`ifdef FANOUT_CHK_POPCOUNT_EN
    // Increment by the number of failing replicas this cycle.
    always_comb begin
        inc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            inc = inc + SUM_W'(mism[i]);
        end
    end
`else
    assign inc = SUM_W'(1);
`endif

    assign sum     = {{(IDX_W + 1){1'b0}}, cnt_q} + inc;
    assign cnt_sat = (sum > CNT_MAX) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

    // Next-state and result update; stop in CHECK still lets that cycle's compare land.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.stop) begin
                    state_d = ST_DONE;
                end else if (settle_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (!src_edge && (mism != '0)) begin
                    err_d = 1'b1;
                    cnt_d = cnt_sat;
                    if (!err_q) idx_d = low_idx;
                end
                if (bus.stop) begin
                    state_d = ST_DONE;
                end else if (src_edge) begin
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and result registers; reset aborts any window silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= 4'd0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
        end
    end

    assign bus.busy      = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
    assign bus.err_cnt   = cnt_q;
    assign bus.first_idx = idx_q;
endmodule

// File: tb/tb_fanout_capture_checker.sv
// Purpose: directed scoreboard bench for fanout_capture_checker (WIDTH=20, CNT_W=4, SETTLE=2).
// Latency: expectations are tagged with the edge count after which they must hold.
// Backpressure: none; the monitor samples on every falling edge.
module tb_fanout_capture_checker;
    localparam int WIDTH = 20;
    localparam int IDX_W = 5;
    localparam int CNT_W = 4;
`ifdef FANOUT_CHK_POPCOUNT_EN
    localparam int MB = 2;
`else
    localparam int MB = 1;
`endif

    typedef struct {
        int          cyc;
        string       nm;
        logic [11:0] v;   // {busy, done, err, err_cnt[3:0], first_idx[4:0]}
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    fanout_capture_checker_if #(.WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    fanout_capture_checker #(
        .WIDTH(WIDTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .SETTLE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expect_at(input string nm, input int c, input bit b, input bit d,
                             input bit e, input int cnt, input int idx);
        exp_t x;
        x.cyc = c;
        x.nm  = nm;
        x.v   = {b, d, e, 4'(cnt), 5'(idx)};
        sb.push_back(x);
    endtask

    // Monitor: pops every expectation due this cycle and checks done pulses are expected.
    always @(negedge clk) begin
        logic [11:0] act;
        exp_t        x;
        bit          covered;
        covered = 1'b0;
        act = {bus.busy, bus.done, bus.err, bus.err_cnt, bus.first_idx};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            total++;
            if (x.cyc < cyc) begin
                bad++;
                $display("FAIL %s missed: due cyc=%0d seen at cyc=%0d", x.nm, x.cyc, cyc);
            end else begin
                if (x.v[10]) covered = 1'b1;
                if (act !== x.v) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got busy=%b done=%b err=%b cnt=%0d idx=%0d want busy=%b done=%b err=%b cnt=%0d idx=%0d",
                             x.nm, cyc, act[11], act[10], act[9], act[8:5], act[4:0],
                             x.v[11], x.v[10], x.v[9], x.v[8:5], x.v[4:0]);
                end
            end
        end
        if (bus.done === 1'b1 && !covered) begin
            total++;
            bad++;
            $display("FAIL unexpected_done cyc=%0d got done=1 want done=0", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a, b, c, d, e, f, g;
        rst = 1'b1;
        bus.src = 1'b1;
        bus.rep = '1;
        bus.start = 1'b0;
        bus.stop = 1'b0;
        tick(); tick(); tick();
        expect_at("reset", cyc, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Clean run
        tick(); a = cyc; bus.start = 1'b1;
        go(a + 1); bus.start = 1'b0;
        expect_at("clean_busy", a + 1, 1, 0, 0, 0, 0);
        expect_at("clean_check", a + 3, 1, 0, 0, 0, 0);
        go(a + 10); bus.stop = 1'b1;
        expect_at("clean_done", a + 11, 0, 1, 0, 0, 0);
        go(a + 11); bus.stop = 1'b0;
        expect_at("clean_idle", a + 12, 0, 0, 0, 0, 0);

        // Single fault on rep[7] for three captured samples
        go(a + 13); b = cyc; bus.start = 1'b1;
        go(b + 1); bus.start = 1'b0;
        go(b + 4); bus.rep[7] = 1'b0;
        expect_at("single_lat", b + 5, 1, 0, 0, 0, 0);
        expect_at("single_1", b + 6, 1, 0, 1, 1, 7);
        expect_at("single_2", b + 7, 1, 0, 1, 2, 7);
        go(b + 7); bus.rep = '1;
        expect_at("single_3", b + 8, 1, 0, 1, 3, 7);
        expect_at("single_clean", b + 9, 1, 0, 1, 3, 7);
        go(b + 9); bus.stop = 1'b1;
        expect_at("single_done", b + 10, 0, 1, 1, 3, 7);
        go(b + 10); bus.stop = 1'b0;
        expect_at("single_hold", b + 11, 0, 0, 1, 3, 7);

        // Two replicas wrong for one sample
        go(b + 12); c = cyc; bus.start = 1'b1;
        go(c + 1); bus.start = 1'b0;
        expect_at("start_clears", c + 1, 1, 0, 0, 0, 0);
        go(c + 4); bus.rep[3] = 1'b0; bus.rep[12] = 1'b0;
        go(c + 5); bus.rep = '1;
        expect_at("multi_lat", c + 5, 1, 0, 0, 0, 0);
        expect_at("multi", c + 6, 1, 0, 1, MB, 3);
        go(c + 7); bus.stop = 1'b1;
        expect_at("multi_done", c + 8, 0, 1, 1, MB, 3);
        go(c + 8); bus.stop = 1'b0;

        // Source toggle with lagging replicas, then a mask-length probe
        go(c + 10); d = cyc; bus.src = 1'b0; bus.rep = '0; bus.start = 1'b1;
        go(d + 1); bus.start = 1'b0;
        go(d + 5); bus.src = 1'b1;
        go(d + 6); bus.rep = '1;
        expect_at("toggle_mask", d + 7, 1, 0, 0, 0, 0);
        expect_at("toggle_resume", d + 10, 1, 0, 0, 0, 0);
        expect_at("toggle_clean", d + 12, 1, 0, 0, 0, 0);
        go(d + 12); bus.src = 1'b0; bus.rep = 20'h00020;
        expect_at("mask_len", d + 16, 1, 0, 0, 0, 0);
        go(d + 16); bus.rep = '0;
        expect_at("mask_end", d + 17, 1, 0, 1, 1, 5);
        go(d + 18); bus.stop = 1'b1;
        expect_at("toggle_done", d + 19, 0, 1, 1, 1, 5);
        go(d + 19); bus.stop = 1'b0;

        // Saturation with persistent fault on the top replica
        go(d + 20); e = cyc; bus.start = 1'b1;
        go(e + 1); bus.start = 1'b0;
        go(e + 3); bus.rep[19] = 1'b1;
        expect_at("sat_lat", e + 4, 1, 0, 0, 0, 0);
        expect_at("sat_first", e + 5, 1, 0, 1, 1, 19);
        expect_at("sat_14", e + 18, 1, 0, 1, 14, 19);
        expect_at("sat_15", e + 19, 1, 0, 1, 15, 19);
        expect_at("sat_hold", e + 24, 1, 0, 1, 15, 19);
        expect_at("sat_hold2", e + 26, 1, 0, 1, 15, 19);
        go(e + 26); bus.stop = 1'b1;
        expect_at("sat_done", e + 27, 0, 1, 1, 15, 19);
        go(e + 27); bus.stop = 1'b0; bus.rep = '0;

        // start and stop together in IDLE, then stop during SETTLE
        go(e + 28); f = cyc; bus.start = 1'b1; bus.stop = 1'b1;
        expect_at("start_wins", f + 1, 1, 0, 0, 0, 0);
        go(f + 1); bus.start = 1'b0;
        expect_at("stop_settle", f + 2, 0, 1, 0, 0, 0);
        go(f + 2); bus.stop = 1'b0;
        expect_at("stop_idle", f + 3, 0, 0, 0, 0, 0);

        // Reset in CHECK with err set
        go(f + 4); g = cyc; bus.start = 1'b1; bus.rep[2] = 1'b1;
        go(g + 1); bus.start = 1'b0;
        expect_at("pre_rst_err", g + 4, 1, 0, 1, 1, 2);
        go(g + 4); rst = 1'b1;
        expect_at("rst_abort", g + 5, 0, 0, 0, 0, 0);
        go(g + 5); rst = 1'b0; bus.rep = '0;
        expect_at("rst_no_done", g + 6, 0, 0, 0, 0, 0);
        expect_at("rst_idle", g + 7, 0, 0, 0, 0, 0);

        go(g + 8);
        for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain got pending=%0d want pending=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
